// File: rtl/adsr_envelope_pkg.sv
// Shared types and helpers for the ADSR amplitude envelope.
// The state enum and the envelope full-scale helper are used by the envelope top.
package adsr_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

    function automatic logic [31:0] env_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/adsr_envelope_gain.sv
// Registered signed-sample by unsigned-envelope gain stage, one cycle of latency.
// The envelope acts as a fraction of unity: full scale is just under a gain of one.
module envelope_gain #(
    parameter int BIT_WIDTH = 16,
    parameter int ENV_WIDTH = 16
) (
    input  logic                        clk_audio,
    input  logic                        reset,
    input  logic signed [BIT_WIDTH-1:0] i_level,
    input  logic        [ENV_WIDTH-1:0] i_envelope,
    output logic signed [BIT_WIDTH-1:0] o_level
);

    logic signed [ENV_WIDTH:0]           w_gain;
    logic signed [BIT_WIDTH+ENV_WIDTH:0] w_product;
    logic signed [BIT_WIDTH-1:0]         r_level;
    logic                                w_unused;

    assign w_gain    = $signed({1'b0, i_envelope});
    assign w_product = i_level * w_gain;

    // Taking the slice above the fraction bits is an arithmetic shift with floor rounding.
    assign w_unused  = ^{w_product[BIT_WIDTH+ENV_WIDTH], w_product[ENV_WIDTH-1:0]};

    always_ff @(posedge clk_audio or posedge reset) begin
        if (reset) begin
            r_level <= '0;
        end else begin
            r_level <= w_product[ENV_WIDTH +: BIT_WIDTH];
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator: gate-driven state machine, saturating envelope register,
// and a one-cycle gain stage applying the envelope to the incoming PCM sample.
module adsr_envelope
    import adsr_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int ENV_WIDTH = 16
) (
    input  logic                        clk_audio,
    input  logic                        reset,
    input  logic                        gate,
    input  logic        [ENV_WIDTH-1:0] attack_step,
    input  logic        [ENV_WIDTH-1:0] decay_step,
    input  logic        [ENV_WIDTH-1:0] sustain_level,
    input  logic        [ENV_WIDTH-1:0] release_step,
    input  logic signed [BIT_WIDTH-1:0] level_in,
    output logic signed [BIT_WIDTH-1:0] level_out,
    output logic        [ENV_WIDTH-1:0] envelope,
    output logic                        active
);

    localparam logic [ENV_WIDTH:0] ENV_MAX = (ENV_WIDTH+1)'(env_max(ENV_WIDTH));

    adsr_state_t               r_state;
    adsr_state_t               w_nextState;
    logic [ENV_WIDTH-1:0]      r_envelope;
    logic [ENV_WIDTH-1:0]      w_nextEnv;
    logic [ENV_WIDTH:0]        w_attackSum;
    logic signed [ENV_WIDTH:0] w_decayDiff;
    logic signed [ENV_WIDTH:0] w_releaseDiff;

    // One extra bit of headroom lets overflow and underflow be detected and saturated.
    assign w_attackSum   = {1'b0, r_envelope} + {1'b0, attack_step};
    assign w_decayDiff   = $signed({1'b0, r_envelope}) - $signed({1'b0, decay_step});
    assign w_releaseDiff = $signed({1'b0, r_envelope}) - $signed({1'b0, release_step});

    always_comb begin
        w_nextState = r_state;
        w_nextEnv   = r_envelope;
        case (r_state)
            IDLE: begin
                w_nextEnv = '0;
                if (gate) begin
                    w_nextState = ATTACK;
                end
            end
            ATTACK: begin
                if (!gate) begin
                    w_nextState = RELEASE;
                end else if (w_attackSum >= ENV_MAX) begin
                    w_nextEnv   = ENV_MAX[ENV_WIDTH-1:0];
                    w_nextState = DECAY;
                end else begin
                    w_nextEnv = w_attackSum[ENV_WIDTH-1:0];
                end
            end
            DECAY: begin
                if (!gate) begin
                    w_nextState = RELEASE;
                end else if (w_decayDiff <= $signed({1'b0, sustain_level})) begin
                    w_nextEnv   = sustain_level;
                    w_nextState = SUSTAIN;
                end else begin
                    w_nextEnv = w_decayDiff[ENV_WIDTH-1:0];
                end
            end
            SUSTAIN: begin
                w_nextEnv = sustain_level;
                if (!gate) begin
                    w_nextState = RELEASE;
                end
            end
            RELEASE: begin
                // Retrigger keeps the current level so attack resumes without a click.
                if (gate) begin
                    w_nextState = ATTACK;
                end else if (w_releaseDiff[ENV_WIDTH] || (w_releaseDiff == '0)) begin
                    w_nextEnv   = '0;
                    w_nextState = IDLE;
                end else begin
                    w_nextEnv = w_releaseDiff[ENV_WIDTH-1:0];
                end
            end
            default: begin
                w_nextState = IDLE;
                w_nextEnv   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_audio or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_envelope <= '0;
        end else begin
            r_state    <= w_nextState;
            r_envelope <= w_nextEnv;
        end
    end

    envelope_gain #(
        .BIT_WIDTH (BIT_WIDTH),
        .ENV_WIDTH (ENV_WIDTH)
    ) u_gain (
        .clk_audio  (clk_audio),
        .reset      (reset),
        .i_level    (level_in),
        .i_envelope (r_envelope),
        .o_level    (level_out)
    );

    assign envelope = r_envelope;
    assign active   = (r_state != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus randomized gate/step
// traffic, all compared against an integer-arithmetic behavioural model.
module tb_adsr_envelope;

    localparam int BW        = 16;
    localparam int EW        = 16;
    localparam int ENV_FULL  = 65535;
    localparam int M_IDLE    = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_DECAY   = 2;
    localparam int M_SUSTAIN = 3;
    localparam int M_RELEASE = 4;

    logic                 clk_audio = 1'b0;
    logic                 reset;
    logic                 gate;
    logic [EW-1:0]        attack_step;
    logic [EW-1:0]        decay_step;
    logic [EW-1:0]        sustain_level;
    logic [EW-1:0]        release_step;
    logic signed [BW-1:0] level_in;
    logic signed [BW-1:0] level_out;
    logic [EW-1:0]        envelope;
    logic                 active;

    int vectors     = 0;
    int miscompares = 0;
    int mState      = M_IDLE;
    int mEnv        = 0;
    int mOut        = 0;

    always #5 clk_audio = ~clk_audio;

    adsr_envelope #(
        .BIT_WIDTH (BW),
        .ENV_WIDTH (EW)
    ) dut (
        .clk_audio     (clk_audio),
        .reset         (reset),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .level_in      (level_in),
        .level_out     (level_out),
        .envelope      (envelope),
        .active        (active)
    );

    // Gain as a true fraction of 65536, floored toward minus infinity.
    function automatic int floorScale(input int sample, input int env);
        longint p;
        p = longint'(sample) * longint'(env);
        if (p >= 0) return int'(p / 65536);
        return -int'((-p + 65535) / 65536);
    endfunction

    task automatic modelEdge();
        int a;
        int d;
        int s;
        int r;
        a = int'(attack_step);
        d = int'(decay_step);
        s = int'(sustain_level);
        r = int'(release_step);
        mOut = floorScale(int'(level_in), mEnv);
        case (mState)
            M_IDLE: begin
                mEnv = 0;
                if (gate) mState = M_ATTACK;
            end
            M_ATTACK: begin
                if (!gate) mState = M_RELEASE;
                else if (mEnv + a >= ENV_FULL) begin mEnv = ENV_FULL; mState = M_DECAY; end
                else mEnv = mEnv + a;
            end
            M_DECAY: begin
                if (!gate) mState = M_RELEASE;
                else if (mEnv - d <= s) begin mEnv = s; mState = M_SUSTAIN; end
                else mEnv = mEnv - d;
            end
            M_SUSTAIN: begin
                mEnv = s;
                if (!gate) mState = M_RELEASE;
            end
            default: begin
                if (gate) mState = M_ATTACK;
                else if (mEnv - r <= 0) begin mEnv = 0; mState = M_IDLE; end
                else mEnv = mEnv - r;
            end
        endcase
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk_audio);
        #1;
    endtask

    task automatic modelReset();
        mState = M_IDLE;
        mEnv   = 0;
        mOut   = 0;
    endtask

    task automatic reachSustain8000();
        gate          = 1'b1;
        attack_step   = 16'h8000;
        decay_step    = 16'hFFFF;
        sustain_level = 16'h8000;
        repeat (5) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        vectors++;
        if (envelope !== 16'h0000 || active !== 1'b0 || level_out !== 16'sh0000) begin
            miscompares++;
            $display("[TB] FAIL reset_initial: got env=%h act=%b out=%h expected 0000/0/0000", envelope, active, level_out);
        end
        @(negedge clk_audio);
        reset = 1'b0;
        modelReset();
        level_in = 16'sh4000;
        reachSustain8000();
        vectors++;
        if (envelope !== 16'h8000 || active !== 1'b1 || level_out !== 16'sh2000) begin
            miscompares++;
            $display("[TB] FAIL reset_presustain: got env=%h act=%b out=%h expected 8000/1/2000", envelope, active, level_out);
        end
        #2;
        reset = 1'b1;
        #1;
        vectors++;
        if (envelope !== 16'h0000 || active !== 1'b0 || level_out !== 16'sh0000) begin
            miscompares++;
            $display("[TB] FAIL reset_midsustain: got env=%h act=%b out=%h expected 0000/0/0000", envelope, active, level_out);
        end
        @(negedge clk_audio);
        reset = 1'b0;
        modelReset();
        gate     = 1'b0;
        level_in = 16'sh7FFF;
        tick();
        vectors++;
        if (level_out !== 16'sh0000 || envelope !== 16'h0000 || active !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_idle_mute: got env=%h act=%b out=%h expected 0000/0/0000", envelope, active, level_out);
        end
    endtask

    task automatic test_attack_decay();
        logic [15:0] expEnv [13] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'hFFFF, 16'hEFFF,
                                     16'hDFFF, 16'hCFFF, 16'hBFFF, 16'hAFFF, 16'h9FFF, 16'h8FFF, 16'h8000};
        attack_step   = 16'h4000;
        decay_step    = 16'h1000;
        sustain_level = 16'h8000;
        gate          = 1'b1;
        for (int i = 0; i < 13; i++) begin
            level_in = 16'($urandom);
            tick();
            vectors++;
            if (envelope !== expEnv[i] || envelope !== 16'(mEnv)) begin
                miscompares++;
                $display("[TB] FAIL attack_decay_env[%0d]: got %h expected %h", i, envelope, expEnv[i]);
            end
            vectors++;
            if (active !== 1'b1 || level_out !== 16'(mOut)) begin
                miscompares++;
                $display("[TB] FAIL attack_decay_out[%0d]: got act=%b out=%h expected 1/%h", i, active, level_out, 16'(mOut));
            end
        end
    endtask

    task automatic test_gain();
        logic [15:0] inTab  [6] = '{16'h4000, 16'hC000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0000};
        logic [15:0] susTab [6] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h8000};
        logic [15:0] outTab [6] = '{16'h2000, 16'hE000, 16'h0000, 16'h7FFE, 16'h8000, 16'h0000};
        gate = 1'b1;
        for (int i = 0; i < 6; i++) begin
            level_in      = inTab[i];
            sustain_level = susTab[i];
            tick();
            vectors++;
            if (level_out !== outTab[i] || level_out !== 16'(mOut)) begin
                miscompares++;
                $display("[TB] FAIL gain[%0d]: got %h expected %h", i, level_out, outTab[i]);
            end
            vectors++;
            if (envelope !== 16'(mEnv)) begin
                miscompares++;
                $display("[TB] FAIL gain_env[%0d]: got %h expected %h", i, envelope, 16'(mEnv));
            end
        end
    endtask

    task automatic test_release();
        logic [15:0] expEnv [4] = '{16'h8000, 16'h5000, 16'h2000, 16'h0000};
        logic        expAct [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        gate         = 1'b0;
        release_step = 16'h3000;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (envelope !== expEnv[i] || active !== expAct[i] || envelope !== 16'(mEnv)) begin
                miscompares++;
                $display("[TB] FAIL release[%0d]: got env=%h act=%b expected %h/%b", i, envelope, active, expEnv[i], expAct[i]);
            end
        end
    endtask

    task automatic test_retrigger();
        logic [15:0] expEnv [6] = '{16'h8000, 16'h5000, 16'h5000, 16'h9000, 16'hD000, 16'hFFFF};
        reachSustain8000();
        release_step = 16'h3000;
        for (int i = 0; i < 6; i++) begin
            gate        = (i >= 2);
            attack_step = 16'h4000;
            tick();
            vectors++;
            if (envelope !== expEnv[i] || active !== 1'b1 || envelope !== 16'(mEnv)) begin
                miscompares++;
                $display("[TB] FAIL retrigger[%0d]: got env=%h act=%b expected %h/1", i, envelope, active, expEnv[i]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] atkTab [6] = '{16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic [15:0] susTab [6] = '{16'h1000, 16'h1000, 16'h1000, 16'h1000, 16'hD000, 16'hE000};
        logic [15:0] expEnv [6] = '{16'h0000, 16'h0001, 16'hFFFF, 16'hC000, 16'hD000, 16'hE000};
        reset = 1'b1;
        #1;
        @(negedge clk_audio);
        reset = 1'b0;
        modelReset();
        gate       = 1'b1;
        decay_step = 16'h3FFF;
        level_in   = 16'sh7FFF;
        for (int i = 0; i < 6; i++) begin
            attack_step   = atkTab[i];
            sustain_level = susTab[i];
            tick();
            vectors++;
            if (envelope !== expEnv[i] || envelope !== 16'(mEnv)) begin
                miscompares++;
                $display("[TB] FAIL saturation[%0d]: got %h expected %h", i, envelope, expEnv[i]);
            end
        end
        vectors++;
        if (level_out !== 16'(mOut)) begin
            miscompares++;
            $display("[TB] FAIL saturation_out: got %h expected %h", level_out, 16'(mOut));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 11) == 0) gate = ~gate;
            attack_step  = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h2000));
            decay_step   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h2000));
            release_step = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h2000));
            if ($urandom_range(0, 19) == 0) sustain_level = 16'($urandom);
            level_in = 16'($urandom);
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b1;
                #1;
                vectors++;
                if (envelope !== 16'h0000 || active !== 1'b0 || level_out !== 16'sh0000) begin
                    miscompares++;
                    $display("[TB] FAIL rand_reset[%0d]: got env=%h act=%b out=%h expected 0000/0/0000", i, envelope, active, level_out);
                end
                @(negedge clk_audio);
                reset = 1'b0;
                modelReset();
            end
            tick();
            vectors++;
            if (envelope !== 16'(mEnv) || active !== (mState != M_IDLE) || level_out !== 16'(mOut)) begin
                miscompares++;
                $display("[TB] FAIL rand[%0d]: got env=%h act=%b out=%h expected %h/%b/%h",
                         i, envelope, active, level_out, 16'(mEnv), (mState != M_IDLE), 16'(mOut));
            end
        end
    endtask

    initial begin
        reset         = 1'b1;
        gate          = 1'b0;
        attack_step   = '0;
        decay_step    = '0;
        sustain_level = '0;
        release_step  = '0;
        level_in      = '0;
        test_reset();
        test_attack_decay();
        test_gain();
        test_release();
        test_retrigger();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
